// File: rtl/autopilot_controller.sv
// Autopilot for a side-scrolling runner: jumps over ground obstacles, optionally ducks flyers,
// and re-launches the game after a crash. Optional feature macro: AUTOPILOT_DUCK_EN.
module autopilot_controller #(
  parameter int unsigned N_OBS          = 2,
  parameter int unsigned POS_W          = 10,
  parameter int unsigned PLAYER_OFFSET  = 6,
  parameter int unsigned JUMP_THRESHOLD = 40,
  parameter int unsigned HOLD_FRAMES    = 8,
  parameter int unsigned RESTART_DELAY  = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic [N_OBS*POS_W-1:0] obstacle_pos,
  input  logic [N_OBS-1:0]       obstacle_valid,
  input  logic [N_OBS-1:0]       obstacle_high,
  input  logic                   crash,
  output logic                   button_up,
  output logic                   button_down,
  output logic                   crash_out
);

  localparam int unsigned CNT_W = (RESTART_DELAY < 1) ? 1 : $clog2(RESTART_DELAY + 1);

  localparam logic [POS_W-1:0] LP_OFFSET = POS_W'(PLAYER_OFFSET);
  localparam logic [POS_W-1:0] LP_THRESH = POS_W'(JUMP_THRESHOLD);
  localparam logic [7:0]       LP_HOLD   = 8'(HOLD_FRAMES);
  localparam logic [CNT_W:0]   LP_DELAY  = (CNT_W + 1)'(RESTART_DELAY);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_JUMP    = 3'd2;
  localparam logic [2:0] S_CRASHED = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;

  logic [2:0]       r_state;
  logic [7:0]       r_hold;
  logic [CNT_W-1:0] r_rcnt;
  logic             r_button_up;
  logic             r_button_down;
  logic             r_crash_out;

  logic [2:0]       w_state_next;
  logic [7:0]       w_hold_next;
  logic [CNT_W-1:0] w_rcnt_next;
  logic             w_up_next;
  logic             w_down_next;
  logic             w_crash_next;

  logic [N_OBS-1:0] w_in_window;
  logic [N_OBS-1:0] w_duck_ok;
  logic             w_jump_trig;
  logic             w_duck_any;
  logic [CNT_W:0]   w_rcnt_inc;

  // Window strictly past the player and no farther out than the trigger distance.
  for (genvar g = 0; g < N_OBS; g++) begin : g_win
    logic [POS_W-1:0] w_pos;
    assign w_pos          = obstacle_pos[g*POS_W +: POS_W];
    assign w_in_window[g] = obstacle_valid[g] && (w_pos > LP_OFFSET) && (w_pos <= LP_THRESH);
  end

`ifdef AUTOPILOT_DUCK_EN
  assign w_duck_ok = w_in_window & obstacle_high;
`else
  logic w_unused_high;
  assign w_duck_ok     = '0;
  assign w_unused_high = ^obstacle_high;
`endif

  assign w_jump_trig = |(w_in_window & ~w_duck_ok);
  assign w_duck_any  = |w_duck_ok;
  assign w_rcnt_inc  = {1'b0, r_rcnt} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_rcnt_next  = r_rcnt;
    w_up_next    = r_button_up;
    w_down_next  = 1'b0;
    w_crash_next = r_crash_out;

    if (!enable) begin
      w_state_next = S_IDLE;
      w_hold_next  = 8'd0;
      w_rcnt_next  = '0;
      w_up_next    = 1'b0;
      w_crash_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_RUN;
          w_up_next    = 1'b0;
          w_crash_next = 1'b0;
        end

        S_RUN: begin
          if (crash) begin
            w_state_next = S_CRASHED;
            w_crash_next = 1'b1;
            w_up_next    = 1'b0;
            w_rcnt_next  = '0;
          end else if (w_jump_trig) begin
            w_state_next = S_JUMP;
            w_up_next    = 1'b1;
            w_hold_next  = LP_HOLD;
          end else begin
            w_up_next   = 1'b0;
            w_down_next = w_duck_any;
          end
        end

        S_JUMP: begin
          if (crash) begin
            w_state_next = S_CRASHED;
            w_crash_next = 1'b1;
            w_up_next    = 1'b0;
            w_rcnt_next  = '0;
          end else if (frame_tick) begin
            // Guarded decrement: a tick at 1 (or a degenerate 0) ends the jump.
            if (r_hold <= 8'd1) begin
              w_state_next = S_RUN;
              w_up_next    = 1'b0;
              w_hold_next  = 8'd0;
            end else begin
              w_hold_next = r_hold - 8'd1;
            end
          end
        end

        S_CRASHED: begin
          w_rcnt_next = w_rcnt_inc[CNT_W-1:0];
          if (w_rcnt_inc >= LP_DELAY) begin
            w_state_next = S_RESTART;
            w_crash_next = 1'b0;
            w_up_next    = 1'b1;
          end
        end

        S_RESTART: begin
          w_state_next = S_RUN;
          w_up_next    = 1'b0;
        end

        default: begin
          w_state_next = S_IDLE;
          w_hold_next  = 8'd0;
          w_rcnt_next  = '0;
          w_up_next    = 1'b0;
          w_crash_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hold        <= 8'd0;
      r_rcnt        <= '0;
      r_button_up   <= 1'b0;
      r_button_down <= 1'b0;
      r_crash_out   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hold        <= w_hold_next;
      r_rcnt        <= w_rcnt_next;
      r_button_up   <= w_up_next;
      r_button_down <= w_down_next;
      r_crash_out   <= w_crash_next;
    end
  end

  assign button_up   = r_button_up;
  assign button_down = r_button_down;
  assign crash_out   = r_crash_out;

endmodule

// File: doc/autopilot_controller.md
AUTOPILOT_CONTROLLER -- requirements
Module: autopilot_controller

Interface
REQ-001 The block SHALL have parameter N_OBS, default 2, number of obstacle channels (1..8).
REQ-002 The block SHALL have parameter POS_W, default 10, obstacle x-position width in bits.
REQ-003 The block SHALL have parameter PLAYER_OFFSET, default 6, player x-position; obstacles at or below it are ignored.
REQ-004 The block SHALL have parameter JUMP_THRESHOLD, default 40, x-position at or below which a jump triggers.
REQ-005 The block SHALL have parameter HOLD_FRAMES, default 8, frame ticks button_up is held per jump (1..255).
REQ-006 The block SHALL have parameter RESTART_DELAY, default 60, clk cycles between crash capture and restart pulse.
REQ-007 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 The block SHALL have port enable, input, 1, autopilot enable.
REQ-010 The block SHALL have port frame_tick, input, 1, one-cycle game-frame strobe.
REQ-011 The block SHALL have port obstacle_pos, input, N_OBS*POS_W, packed positions; channel i at bits [i*POS_W +: POS_W].
REQ-012 The block SHALL have port obstacle_valid, input, N_OBS, per-channel valid.
REQ-013 The block SHALL have port obstacle_high, input, N_OBS, per-channel flying-obstacle flag.
REQ-014 The block SHALL have port crash, input, 1, collision level from game core.
REQ-015 The block SHALL have port button_up, output, 1, jump request, registered.
REQ-016 The block SHALL have port button_down, output, 1, duck request, registered.
REQ-017 The block SHALL have port crash_out, output, 1, crash-latched indicator, registered.

Function
REQ-018 in_window[i] SHALL be obstacle_valid[i] & (pos_i > PLAYER_OFFSET) & (pos_i <= JUMP_THRESHOLD), compared unsigned at POS_W bits.
REQ-019 jump_trig SHALL be the OR over channels of in_window[i] & ~duck_ok[i]; duck_ok is defined in Configuration.
REQ-020 The FSM SHALL have states IDLE, RUN, JUMP, CRASHED, RESTART.
REQ-021 Deasserted enable SHALL force IDLE on the next edge from any state and clear all outputs, at highest priority.
REQ-022 IDLE with enable=1 SHALL go to RUN; all outputs are 0 in IDLE.
REQ-023 In RUN or JUMP, crash=1 SHALL go to CRASHED with crash_out=1, button_up=0, button_down=0 and restart counter cleared; crash outranks jump_trig.
REQ-024 RUN with jump_trig=1 SHALL go to JUMP, set button_up=1 one cycle after the sample, and load the hold counter with HOLD_FRAMES.
REQ-025 In JUMP, each frame_tick SHALL decrement the hold counter; the tick that reaches 0 returns to RUN with button_up=0 on that edge; obstacle inputs are ignored in JUMP.
REQ-026 In CRASHED, the counter SHALL increment every cycle; at count == RESTART_DELAY it goes to RESTART with crash_out=0 and button_up=1, and crash is ignored.
REQ-027 RESTART SHALL last exactly one cycle, then go to RUN with button_up=0, regardless of crash.
REQ-028 Counter widths SHALL be $clog2(RESTART_DELAY+1) and 8 bits, and SHALL never wrap.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously set state=IDLE, counters=0, button_up=0, button_down=0, crash_out=0.
REQ-030 Reset mid-jump or mid-crash SHALL abandon the operation with no restart pulse after release.

Configuration
REQ-031 With macro AUTOPILOT_DUCK_EN defined, duck_ok[i] SHALL equal in_window[i] & obstacle_high[i], and button_down SHALL be 1 in RUN while any duck_ok is set and jump_trig=0.
REQ-032 With AUTOPILOT_DUCK_EN defined, jump_trig=1 SHALL override duck with button_down=0, and button_down SHALL be 0 outside RUN.
REQ-033 Without AUTOPILOT_DUCK_EN, duck_ok SHALL be 0, obstacle_high SHALL be unused, and button_down SHALL be constant 0.

Verification
REQ-034 Enable=1, channel 1 valid at pos 41 then 40 -> button_up rises the cycle after pos=40, stays 1 for 8 frame_ticks, then falls.
REQ-035 Pos=6 valid on all channels -> button_up stays 0; pos=7 -> jump.
REQ-036 crash pulse in JUMP -> crash_out=1 and button_up=0 next edge; after 60 cycles crash_out=0 with a single-cycle button_up pulse, then RUN.
REQ-037 crash and jump_trig in the same cycle -> CRASHED, no jump.
REQ-038 With AUTOPILOT_DUCK_EN, channel 0 high at pos 20 -> button_down=1 and button_up=0; adding channel 1 low at pos 30 -> button_up=1 and button_down=0.
REQ-039 rst_n low mid-CRASHED, or enable low mid-JUMP -> all outputs 0; no restart pulse after release.
